// File: rtl/decoder_config_if.sv
// Host-side request/status bundle between the board-init sequencer and decoder_config.
interface decoder_config_if;
    logic [7:0] SuBAddrL;
    logic [7:0] Data;
    logic       write;
    logic       ready;
    logic       errory;

    modport master (output SuBAddrL, Data, write, input  ready, errory);
    modport slave  (input  SuBAddrL, Data, write, output ready, errory);
endinterface

// File: rtl/decoder_config.sv
// I2C single-register write master (START, DEV_ADDR, SUBADDR_H, SuBAddrL, Data, STOP); DECODER_CFG_RETRY_EN adds NACK retries.
// Latency: ready returns 77 I2C_clk cycles after acceptance on success, 23 after a NACK (per attempt when retrying).
// Backpressure: write is ignored while ready=0; SCL is push-pull and slave clock stretching is not honoured.
module decoder_config #(
    parameter logic [7:0]  DEV_ADDR  = 8'h2C,
    parameter logic [7:0]  SUBADDR_H = 8'h00,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic            I2C_clk,
    input  logic            reset,
    decoder_config_if.slave host,
    inout  wire             SDA,
    output logic            SCL
);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
`ifdef DECODER_CFG_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_RWAIT
    } state_t;

    state_t        state, state_d;
    logic [1:0]    ph, ph_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [1:0]    byte_cnt, byte_cnt_d;
    logic [RW-1:0] retry_cnt, retry_d;
    logic          nack_q, nack_d;
    logic          err_q, err_d;
    logic [7:0]    sub_q, data_q;
    logic [7:0]    cur_byte;
    logic          sda_low;

    always_comb begin
        unique case (byte_cnt)
            2'd0:    cur_byte = DEV_ADDR;
            2'd1:    cur_byte = SUBADDR_H;
            2'd2:    cur_byte = sub_q;
            default: cur_byte = data_q;
        endcase
    end

    always_comb begin
        state_d    = state;
        ph_d       = ph;
        bit_cnt_d  = bit_cnt;
        byte_cnt_d = byte_cnt;
        retry_d    = retry_cnt;
        nack_d     = nack_q;
        err_d      = err_q;
        SCL        = 1'b1;
        sda_low    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (host.write) begin
                    state_d    = S_START;
                    ph_d       = '0;
                    byte_cnt_d = '0;
                    bit_cnt_d  = 3'd7;
                    nack_d     = 1'b0;
                    err_d      = 1'b0;
                    retry_d    = '0;
                end
            end
            S_START: begin
                sda_low = ph[0];
                ph_d    = ph + 2'd1;
                if (ph[0]) begin
                    state_d   = S_BYTE;
                    ph_d      = '0;
                    bit_cnt_d = 3'd7;
                end
            end
            S_BYTE: begin
                SCL     = ph[0];
                sda_low = ~cur_byte[bit_cnt];
                ph_d    = ph + 2'd1;
                if (ph[0]) begin
                    ph_d = '0;
                    if (bit_cnt == 3'd0) state_d = S_ACK;
                    else                 bit_cnt_d = bit_cnt - 3'd1;
                end
            end
            S_ACK: begin
                SCL  = ph[0];
                ph_d = ph + 2'd1;
                if (ph[0]) begin
                    ph_d = '0;
                    // An undriven or unknown line reads as NACK.
                    if (SDA == 1'b0) begin
                        if (byte_cnt == 2'd3) begin
                            state_d = S_STOP;
                        end else begin
                            state_d    = S_BYTE;
                            byte_cnt_d = byte_cnt + 2'd1;
                            bit_cnt_d  = 3'd7;
                        end
                    end else begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                SCL     = (ph != 2'd0);
                sda_low = (ph != 2'd2);
                ph_d    = ph + 2'd1;
                if (ph == 2'd2) begin
                    ph_d = '0;
                    if (nack_q && RETRY_EN && (retry_cnt != RETRY_LAST)) begin
                        state_d = S_RWAIT;
                        retry_d = retry_cnt + RW'(1);
                    end else begin
                        state_d = S_IDLE;
                        err_d   = nack_q;
                    end
                end
            end
            S_RWAIT: begin
                state_d    = S_START;
                ph_d       = '0;
                byte_cnt_d = '0;
                bit_cnt_d  = 3'd7;
                nack_d     = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I2C_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ph        <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            retry_cnt <= '0;
            nack_q    <= 1'b0;
            err_q     <= 1'b0;
            sub_q     <= '0;
            data_q    <= '0;
        end else begin
            state     <= state_d;
            ph        <= ph_d;
            bit_cnt   <= bit_cnt_d;
            byte_cnt  <= byte_cnt_d;
            retry_cnt <= retry_d;
            nack_q    <= nack_d;
            err_q     <= err_d;
            if (state == S_IDLE && host.write) begin
                sub_q  <= host.SuBAddrL;
                data_q <= host.Data;
            end
        end
    end

    assign SDA         = sda_low ? 1'b0 : 1'bz;
    assign host.ready  = (state == S_IDLE);
    assign host.errory = err_q;
endmodule

// File: tb/tb_decoder_config.sv
// Directed bench for decoder_config: I2C bus monitor plus ACK/NACK slave model with an SDA pull-up.
module tb_decoder_config;
    logic clk = 1'b0;
    logic reset;
    wire  sda;
    wire  scl;
    decoder_config_if ifc();

    decoder_config dut (
        .I2C_clk (clk),
        .reset   (reset),
        .host    (ifc.slave),
        .SDA     (sda),
        .SCL     (scl)
    );

    always #5 clk = ~clk;

    logic slave_low = 1'b0;
    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;
    wire sda_line = (sda === 1'b0) ? 1'b0 : 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Bus monitor state
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         bit_n     = 0;
    logic [8:0] shreg     = '0;
    logic       scl_prev  = 1'b1;
    logic       sda_prev  = 1'b1;
    logic       sv;
    logic [7:0] bytes[$];
    logic       ack_bits[$];
    int         ack_cyc[$];
    int         slave_nack_until = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        sv = sda_line;
        if (scl_prev && scl && sda_prev && !sv) begin
            start_cnt++;
            bit_n = 0;
        end else if (scl_prev && scl && !sda_prev && sv) begin
            stop_cnt++;
            bit_n = 0;
        end else if (!scl_prev && scl) begin
            shreg = {shreg[7:0], sv};
            bit_n++;
            if (bit_n == 9) begin
                bytes.push_back(shreg[8:1]);
                ack_bits.push_back(shreg[0]);
                ack_cyc.push_back(cyc + 1);
                bit_n = 0;
            end
        end
        scl_prev = scl;
        sda_prev = sv;
    end

    // Slave pulls SDA low for the whole ACK slot unless told to NACK this attempt.
    always @(posedge clk) begin
        #1;
        if (!scl && bit_n == 8 && start_cnt > slave_nack_until) slave_low = 1'b1;
        else if (bit_n != 8) slave_low = 1'b0;
    end

    task automatic start_write(input logic [7:0] sub, input logic [7:0] dat, output int e0);
        @(negedge clk);
        ifc.SuBAddrL = sub;
        ifc.Data     = dat;
        ifc.write    = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        ifc.write    = 1'b0;
        ifc.SuBAddrL = 8'hEE;
        ifc.Data     = 8'hEE;
    endtask

    // Returns the edge index (relative to E0) at which ready was first seen high, or -1.
    task automatic wait_ready(input int n0, input int max, output int n);
        n = n0;
        while (n < max) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ifc.ready) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (scl !== 1'b1)        begin n_fail++; $display("FAIL reset_scl: got %b want 1", scl); end
        n_tests++; if (sda_line !== 1'b1)   begin n_fail++; $display("FAIL reset_sda: got %b want 1 (released)", sda_line); end
        n_tests++; if (ifc.ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b want 1", ifc.ready); end
        n_tests++; if (ifc.errory !== 1'b0) begin n_fail++; $display("FAIL reset_errory: got %b want 0", ifc.errory); end
        reset = 1'b0;
    endtask

    task automatic test_full_write();
        int e0, n, b0, s0, p0;
        logic [7:0] got;
        logic [7:0] exp_b [4];
        exp_b = '{8'h2C, 8'h00, 8'h1B, 8'h5A};
        b0 = bytes.size(); s0 = start_cnt; p0 = stop_cnt;
        slave_nack_until = start_cnt;
        start_write(8'h1B, 8'h5A, e0);
        @(negedge clk);
        n_tests++; if (ifc.ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b want 0", ifc.ready); end
        n_tests++; if (scl !== 1'b1 || sda_line !== 1'b1) begin n_fail++; $display("FAIL full_start1: scl/sda got %b%b want 11", scl, sda_line); end
        @(negedge clk);
        n_tests++; if (scl !== 1'b1 || sda_line !== 1'b0) begin n_fail++; $display("FAIL full_start2: scl/sda got %b%b want 10", scl, sda_line); end
        wait_ready(1, 300, n);
        n_tests++; if (n !== 77)            begin n_fail++; $display("FAIL full_ready_time: got E0+%0d want E0+77", n); end
        n_tests++; if (ifc.errory !== 1'b0) begin n_fail++; $display("FAIL full_errory: got %b want 0", ifc.errory); end
        n_tests++; if (bytes.size() - b0 !== 4) begin n_fail++; $display("FAIL full_nbytes: got %0d want 4", bytes.size() - b0); end
        for (int i = 0; i < 4; i++) begin
            got = (b0 + i < bytes.size()) ? bytes[b0 + i] : 8'hFF;
            n_tests++; if (got !== exp_b[i]) begin n_fail++; $display("FAIL full_byte%0d: got %h want %h", i, got, exp_b[i]); end
            if (b0 + i < ack_cyc.size()) begin
                n_tests++; if (ack_cyc[b0 + i] - e0 !== 20 + 18 * i) begin n_fail++; $display("FAIL full_ack_time%0d: got E0+%0d want E0+%0d", i, ack_cyc[b0 + i] - e0, 20 + 18 * i); end
                n_tests++; if (ack_bits[b0 + i] !== 1'b0) begin n_fail++; $display("FAIL full_ack%0d: got %b want 0", i, ack_bits[b0 + i]); end
            end
        end
        n_tests++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL full_starts: got %0d want 1", start_cnt - s0); end
        n_tests++; if (stop_cnt - p0 !== 1)  begin n_fail++; $display("FAIL full_stops: got %0d want 1", stop_cnt - p0); end
    endtask

`ifndef DECODER_CFG_RETRY_EN
    task automatic test_nack_dev();
        int e0, n, b0, p0;
        b0 = bytes.size(); p0 = stop_cnt;
        slave_nack_until = start_cnt + 1;
        start_write(8'h33, 8'h44, e0);
        wait_ready(0, 300, n);
        n_tests++; if (n !== 23)            begin n_fail++; $display("FAIL nack_ready_time: got E0+%0d want E0+23", n); end
        n_tests++; if (ifc.errory !== 1'b1) begin n_fail++; $display("FAIL nack_errory: got %b want 1", ifc.errory); end
        n_tests++; if (bytes.size() - b0 !== 1) begin n_fail++; $display("FAIL nack_nbytes: got %0d want 1", bytes.size() - b0); end
        if (bytes.size() > b0) begin
            n_tests++; if (bytes[b0] !== 8'h2C)    begin n_fail++; $display("FAIL nack_byte: got %h want 2c", bytes[b0]); end
            n_tests++; if (ack_bits[b0] !== 1'b1)  begin n_fail++; $display("FAIL nack_ackbit: got %b want 1", ack_bits[b0]); end
        end
        n_tests++; if (stop_cnt - p0 !== 1) begin n_fail++; $display("FAIL nack_stops: got %0d want 1", stop_cnt - p0); end
        repeat (5) @(negedge clk);
        n_tests++; if (ifc.errory !== 1'b1) begin n_fail++; $display("FAIL nack_err_hold: got %b want 1", ifc.errory); end
        n_tests++; if (ifc.ready !== 1'b1)  begin n_fail++; $display("FAIL nack_idle_ready: got %b want 1", ifc.ready); end
    endtask
`else
    task automatic test_retry_recover();
        int e0, n, b0, s0;
        b0 = bytes.size(); s0 = start_cnt;
        slave_nack_until = start_cnt + 2;
        start_write(8'h1B, 8'h5A, e0);
        wait_ready(0, 600, n);
        n_tests++; if (n !== 125)           begin n_fail++; $display("FAIL retry_ready_time: got E0+%0d want E0+125", n); end
        n_tests++; if (ifc.errory !== 1'b0) begin n_fail++; $display("FAIL retry_errory: got %b want 0", ifc.errory); end
        n_tests++; if (start_cnt - s0 !== 3) begin n_fail++; $display("FAIL retry_starts: got %0d want 3", start_cnt - s0); end
        n_tests++; if (bytes.size() - b0 !== 6) begin n_fail++; $display("FAIL retry_nbytes: got %0d want 6", bytes.size() - b0); end
        if (bytes.size() >= b0 + 6) begin
            n_tests++; if (bytes[b0 + 5] !== 8'h5A) begin n_fail++; $display("FAIL retry_data: got %h want 5a", bytes[b0 + 5]); end
        end
    endtask

    task automatic test_retry_exhaust();
        int e0, n, b0, s0;
        b0 = bytes.size(); s0 = start_cnt;
        slave_nack_until = 32'h4000_0000;
        start_write(8'h1B, 8'h5A, e0);
        wait_ready(0, 600, n);
        n_tests++; if (n !== 95)            begin n_fail++; $display("FAIL exhaust_ready_time: got E0+%0d want E0+95", n); end
        n_tests++; if (ifc.errory !== 1'b1) begin n_fail++; $display("FAIL exhaust_errory: got %b want 1", ifc.errory); end
        n_tests++; if (start_cnt - s0 !== 4) begin n_fail++; $display("FAIL exhaust_starts: got %0d want 4", start_cnt - s0); end
        n_tests++; if (bytes.size() - b0 !== 4) begin n_fail++; $display("FAIL exhaust_nbytes: got %0d want 4", bytes.size() - b0); end
    endtask
`endif

    task automatic test_busy_write();
        int e0, n, b0;
        b0 = bytes.size();
        slave_nack_until = start_cnt;
        start_write(8'h1B, 8'h5A, e0);
        @(negedge clk);
        n_tests++; if (ifc.errory !== 1'b0) begin n_fail++; $display("FAIL busy_err_clear: got %b want 0", ifc.errory); end
        repeat (9) @(posedge clk);
        @(negedge clk);
        ifc.write = 1'b1; ifc.Data = 8'hA5; ifc.SuBAddrL = 8'h77;
        @(posedge clk);
        #1;
        ifc.write = 1'b0;
        wait_ready(10, 300, n);
        n_tests++; if (n !== 77) begin n_fail++; $display("FAIL busy_ready_time: got E0+%0d want E0+77", n); end
        n_tests++; if (bytes.size() - b0 !== 4) begin n_fail++; $display("FAIL busy_nbytes: got %0d want 4", bytes.size() - b0); end
        if (bytes.size() >= b0 + 4) begin
            n_tests++; if (bytes[b0 + 2] !== 8'h1B) begin n_fail++; $display("FAIL busy_sub: got %h want 1b", bytes[b0 + 2]); end
            n_tests++; if (bytes[b0 + 3] !== 8'h5A) begin n_fail++; $display("FAIL busy_data: got %h want 5a", bytes[b0 + 3]); end
        end
    endtask

    task automatic test_reset_mid();
        int e0, n, b0;
        logic [7:0] got;
        logic [7:0] exp_b [4];
        exp_b = '{8'h2C, 8'h00, 8'hC3, 8'h96};
        slave_nack_until = start_cnt;
        start_write(8'h1B, 8'h5A, e0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ifc.ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", ifc.ready); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (scl !== 1'b1)        begin n_fail++; $display("FAIL rstmid_scl: got %b want 1", scl); end
        n_tests++; if (sda_line !== 1'b1)   begin n_fail++; $display("FAIL rstmid_sda: got %b want 1 (released)", sda_line); end
        n_tests++; if (ifc.ready !== 1'b1)  begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", ifc.ready); end
        n_tests++; if (ifc.errory !== 1'b0) begin n_fail++; $display("FAIL rstmid_errory: got %b want 0", ifc.errory); end
        reset = 1'b0;
        b0 = bytes.size();
        start_write(8'hC3, 8'h96, e0);
        wait_ready(0, 300, n);
        n_tests++; if (n !== 77)            begin n_fail++; $display("FAIL rstmid_ready_time: got E0+%0d want E0+77", n); end
        n_tests++; if (ifc.errory !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_errory: got %b want 0", ifc.errory); end
        n_tests++; if (bytes.size() - b0 !== 4) begin n_fail++; $display("FAIL rstmid_nbytes: got %0d want 4", bytes.size() - b0); end
        for (int i = 0; i < 4; i++) begin
            got = (b0 + i < bytes.size()) ? bytes[b0 + i] : 8'hFF;
            n_tests++; if (got !== exp_b[i]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h want %h", i, got, exp_b[i]); end
        end
    endtask

    initial begin
        reset        = 1'b1;
        ifc.write    = 1'b0;
        ifc.SuBAddrL = 8'h00;
        ifc.Data     = 8'h00;
        test_reset();
        test_full_write();
`ifndef DECODER_CFG_RETRY_EN
        test_nack_dev();
`else
        test_retry_recover();
        test_retry_exhaust();
`endif
        test_busy_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
